// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the I/D line-port arbiter: FSM states, latched operation
// kind and the IDLE grant decision used by the top-level FSM.
package arbiter_types;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IMEM,
        ARB_DMEM
    } arb_state_t;

    typedef enum logic {
        ARB_OP_READ,
        ARB_OP_WRITE
    } arb_op_t;

    // Data side wins unless the instruction side has waited out its budget.
    function automatic arb_state_t arb_grant(
        input logic i_req,
        input logic d_req,
        input logic starved
    );
        if (d_req && !(i_req && starved)) begin
            return ARB_DMEM;
        end
        if (i_req) begin
            return ARB_IMEM;
        end
        return ARB_IDLE;
    endfunction

endpackage

// File: rtl/cacheline_mem_arbiter_starve_ctr.sv
// Saturating count of data grants taken while an instruction fetch waits;
// clear has priority over increment.
module arb_starve_ctr
    import arbiter_types::*;
#(
    parameter int MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_max
);

    localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

    // NOTE: state is updated with <= so every reader samples the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates one full-line memory transaction at a time between the I-cache
// and D-cache, data first, with a starvation guard for instruction fetch.
module cacheline_mem_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W     = 256,
    parameter int STARVE_MAX = 4     // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t          state;
    arb_state_t          state_nxt;

    logic [31:0]         addr_q;
    logic [LINE_W-1:0]   wdata_q;
    arb_op_t             op_q;

    logic                d_req;
    logic                grant_i;
    logic                grant_d;
    logic                ctr_inc;
    logic                ctr_clr;
    logic                starved;
    logic [STARVE_W-1:0] starve_cnt;

    assign d_req = d_read | d_write;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
    assign ctr_inc = grant_d && i_read;
    assign ctr_clr = grant_i || ((state == ARB_IDLE) && !i_read);

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (ctr_inc),
        .clr    (ctr_clr),
        .cnt    (starve_cnt),
        .at_max (starved)
    );

    // ------------------------------------------------------------------
    // State register and latched request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the request latches are reset too, so pmem outputs are defined from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= ARB_OP_READ;
        end else if (grant_d) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            op_q    <= d_write ? ARB_OP_WRITE : ARB_OP_READ;
        end else if (grant_i) begin
            addr_q  <= i_addr;
            wdata_q <= '0;
            op_q    <= ARB_OP_READ;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            ARB_IDLE: begin
                state_nxt = arb_grant(i_read, d_req, starved);
                grant_i   = (state_nxt == ARB_IMEM);
                grant_d   = (state_nxt == ARB_DMEM);
            end
            ARB_IMEM, ARB_DMEM: begin
                if (pmem_resp) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: state plus latched request only, so an async reset
    // drops the strobes without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        i_rdata    = '0;
        d_resp     = 1'b0;
        d_rdata    = '0;
        case (state)
            ARB_IMEM: begin
                pmem_read = 1'b1;
                pmem_addr = addr_q;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = pmem_rdata;
                end
            end
            ARB_DMEM: begin
                pmem_read  = (op_q == ARB_OP_READ);
                pmem_write = (op_q == ARB_OP_WRITE);
                pmem_addr  = addr_q;
                pmem_wdata = wdata_q;
                if (pmem_resp) begin
                    d_resp = 1'b1;
                    if (op_q == ARB_OP_READ) begin
                        d_rdata = pmem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Simulation-only protocol checks
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write));
            assert (!(pmem_read && pmem_write));
            assert (!(i_resp && d_resp));
            assert (starve_cnt <= STARVE_W'(STARVE_MAX));
        end
    end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: latency, priority, starvation
// guard, late deassert, async reset abort and a small scoreboarded random mix.
module tb_cacheline_mem_arbiter;
    import arbiter_types::*;

    localparam int LINE_W     = 256;
    localparam int STARVE_MAX = 4;

    typedef logic [LINE_W-1:0] line_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    line_t       i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    line_t       d_wdata;
    line_t       d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    line_t       pmem_wdata;
    line_t       pmem_rdata;
    logic        pmem_resp;

    int n_cmp = 0;
    int n_bad = 0;
    int i_resp_seen = 0;
    int d_resp_seen = 0;

    cacheline_mem_arbiter #(
        .LINE_W     (LINE_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_resp) i_resp_seen <= i_resp_seen + 1;
        if (d_resp) d_resp_seen <= d_resp_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input line_t got, input line_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            tick();
            n++;
        end
        check({tag, " grant"}, line_t'(n < 20), line_t'(1));
    endtask

    task automatic respond(input line_t data);
        pmem_rdata = data;
        pmem_resp  = 1'b1;
        #1;
    endtask

    task automatic release_mem();
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
    endtask

    function automatic line_t line_of(input logic [31:0] a);
        return {8{a ^ 32'hDEAD_BEEF}};
    endfunction

    initial begin
        line_t       pat;
        logic        i_pend;
        logic        d_pend;
        logic        exp_d;
        logic [31:0] exp_addr;
        int          mcnt;
        int          issued_i;
        int          issued_d;
        int          base_i;
        int          base_d;
        int          lat;

        rst        = 1'b1;
        i_read     = 1'b0;
        i_addr     = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        #1;

        // ---------------- reset state ----------------
        check("rst state",      line_t'(dut.state), line_t'(ARB_IDLE));
        check("rst starve_cnt", line_t'(dut.starve_cnt), line_t'(0));
        check("rst strobes",    line_t'({pmem_read, pmem_write, i_resp, d_resp}), line_t'(0));
        check("rst pmem_addr",  line_t'(pmem_addr), line_t'(0));
        check("rst pmem_wdata", pmem_wdata, '0);
        check("rst i_rdata",    i_rdata, '0);
        check("rst d_rdata",    d_rdata, '0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // ---------------- lone I read, 5-cycle memory ----------------
        pat    = {32{8'hA5}};
        i_addr = 32'h0000_1000;
        i_read = 1'b1;
        tick();
        check("t1 state c1",     line_t'(dut.state), line_t'(ARB_IMEM));
        check("t1 pmem_read c1", line_t'(pmem_read), line_t'(1));
        check("t1 pmem_addr",    line_t'(pmem_addr), line_t'(32'h0000_1000));
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("t1 read/resp c%0d", c), line_t'({pmem_read, i_resp}), line_t'(2'b10));
        end
        tick();
        respond(pat);
        check("t1 i_resp c5",    line_t'(i_resp), line_t'(1));
        check("t1 i_rdata",      i_rdata, pat);
        check("t1 pmem_read c5", line_t'(pmem_read), line_t'(1));
        check("t1 d_resp",       line_t'(d_resp), line_t'(0));
        i_read = 1'b0;
        release_mem();
        check("t1 state c6",     line_t'(dut.state), line_t'(ARB_IDLE));
        check("t1 idle outputs", line_t'({pmem_read, i_resp}), line_t'(0));
        check("t1 i_rdata idle", i_rdata, '0);
        tick();

        // ---------------- D write beats I read ----------------
        pat     = {16{16'hC0DE}};
        d_addr  = 32'h0000_2000;
        d_wdata = pat;
        d_write = 1'b1;
        i_addr  = 32'h0000_3000;
        i_read  = 1'b1;
        tick();
        check("t2 state",      line_t'(dut.state), line_t'(ARB_DMEM));
        check("t2 strobes",    line_t'({pmem_read, pmem_write}), line_t'(2'b01));
        check("t2 pmem_addr",  line_t'(pmem_addr), line_t'(32'h0000_2000));
        check("t2 pmem_wdata", pmem_wdata, pat);
        check("t2 starve_cnt", line_t'(dut.starve_cnt), line_t'(1));
        repeat (2) tick();
        respond({32{8'h3C}});
        check("t2 d_resp",  line_t'({i_resp, d_resp}), line_t'(2'b01));
        check("t2 d_rdata", d_rdata, '0);
        d_write = 1'b0;
        release_mem();
        check("t2 bubble state",   line_t'(dut.state), line_t'(ARB_IDLE));
        check("t2 bubble strobes", line_t'({pmem_read, pmem_write}), line_t'(0));
        tick();
        check("t2 i state",      line_t'(dut.state), line_t'(ARB_IMEM));
        check("t2 i pmem_addr",  line_t'(pmem_addr), line_t'(32'h0000_3000));
        check("t2 i starve_cnt", line_t'(dut.starve_cnt), line_t'(0));
        pat = {8{32'h1234_5678}};
        respond(pat);
        check("t2 i_resp",  line_t'({i_resp, d_resp}), line_t'(2'b10));
        check("t2 i_rdata", i_rdata, pat);
        i_read = 1'b0;
        release_mem();
        tick();

        // ---------------- starvation guard ----------------
        i_addr = 32'h0000_4000;
        i_read = 1'b1;
        d_addr = 32'h0000_5000;
        d_read = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_busy($sformatf("t3 g%0d", g));
            exp_addr = (g < 4) ? 32'h0000_5000 : 32'h0000_4000;
            check($sformatf("t3 g%0d addr", g), line_t'(pmem_addr), line_t'(exp_addr));
            check($sformatf("t3 g%0d cnt", g), line_t'(dut.starve_cnt), line_t'((g < 4) ? g + 1 : 0));
            respond(line_of(exp_addr));
            check($sformatf("t3 g%0d resp", g), line_t'({i_resp, d_resp}), line_t'((g < 4) ? 2'b01 : 2'b10));
            if (g == 4) begin
                check("t3 i_rdata", i_rdata, line_of(exp_addr));
                i_read = 1'b0;
                d_read = 1'b0;
            end
            release_mem();
            check($sformatf("t3 g%0d bubble", g), line_t'(dut.state), line_t'(ARB_IDLE));
        end
        tick();
        check("t3 cnt final", line_t'(dut.starve_cnt), line_t'(0));

        // ---------------- D drops request after grant ----------------
        base_d = d_resp_seen;
        pat    = {4{64'hFEED_FACE_0BAD_F00D}};
        d_addr = 32'h0000_6000;
        d_read = 1'b1;
        wait_busy("t4");
        d_read = 1'b0;
        repeat (3) tick();
        check("t4 read held",  line_t'({pmem_read, d_resp}), line_t'(2'b10));
        respond(pat);
        check("t4 d_resp",     line_t'(d_resp), line_t'(1));
        check("t4 d_rdata",    d_rdata, pat);
        release_mem();
        repeat (2) tick();
        check("t4 one pulse",  line_t'(d_resp_seen - base_d), line_t'(1));
        check("t4 idle",       line_t'(dut.state), line_t'(ARB_IDLE));

        // ---------------- reset mid-DMEM ----------------
        base_i  = i_resp_seen;
        base_d  = d_resp_seen;
        d_addr  = 32'h0000_7000;
        d_wdata = {32{8'h77}};
        d_write = 1'b1;
        wait_busy("t5");
        d_write = 1'b0;
        tick();
        check("t5 write before rst", line_t'(pmem_write), line_t'(1));
        #2;
        rst = 1'b1;
        #1;
        check("t5 write dropped", line_t'({pmem_read, pmem_write}), line_t'(0));
        check("t5 state",         line_t'(dut.state), line_t'(ARB_IDLE));
        check("t5 addr cleared",  line_t'(pmem_addr), line_t'(0));
        #1;
        rst = 1'b0;
        tick();
        respond({32{8'hEE}});
        check("t5 stray resp", line_t'({i_resp, d_resp}), line_t'(0));
        release_mem();
        check("t5 still idle",  line_t'(dut.state), line_t'(ARB_IDLE));
        check("t5 no pulses",   line_t'((i_resp_seen - base_i) + (d_resp_seen - base_d)), line_t'(0));

        // ---------------- random mix with scoreboard ----------------
        base_i   = i_resp_seen;
        base_d   = d_resp_seen;
        issued_i = 0;
        issued_d = 0;
        i_pend   = 1'b0;
        d_pend   = 1'b0;
        mcnt     = 0;
        tick();
        for (int it = 0; it < 120; it++) begin
            if (it < 40) begin
                if (!i_pend && $urandom_range(1, 0) == 1) begin
                    i_addr = $urandom & 32'hFFFF_FFE0;
                    i_read = 1'b1;
                    i_pend = 1'b1;
                    issued_i++;
                end
                if (!d_pend && $urandom_range(2, 0) != 0) begin
                    d_addr  = $urandom & 32'hFFFF_FFE0;
                    d_wdata = {8{$urandom}};
                    if ($urandom_range(1, 0) == 1) d_write = 1'b1;
                    else                           d_read  = 1'b1;
                    d_pend = 1'b1;
                    issued_d++;
                end
            end
            if (!i_pend && !d_pend) begin
                if (it >= 40) break;
                tick();
                mcnt = 0;
                continue;
            end
            exp_d = d_pend && !(i_pend && mcnt == STARVE_MAX);
            if (exp_d) mcnt = i_pend ? ((mcnt < STARVE_MAX) ? mcnt + 1 : mcnt) : 0;
            else       mcnt = 0;
            exp_addr = exp_d ? d_addr : i_addr;
            wait_busy("t6");
            check("t6 addr", line_t'(pmem_addr), line_t'(exp_addr));
            check("t6 strobes", line_t'({pmem_read, pmem_write}),
                  line_t'((exp_d && d_write) ? 2'b01 : 2'b10));
            check("t6 cnt", line_t'(dut.starve_cnt), line_t'(mcnt));
            if (exp_d && d_write) check("t6 wdata", pmem_wdata, d_wdata);
            lat = $urandom_range(3, 0);
            repeat (lat) tick();
            pat = line_of(exp_addr);
            respond(pat);
            check("t6 resp", line_t'({i_resp, d_resp}), line_t'(exp_d ? 2'b01 : 2'b10));
            check("t6 i_rdata", i_rdata, exp_d ? '0 : pat);
            check("t6 d_rdata", d_rdata, (exp_d && d_read) ? pat : '0);
            if (exp_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
                d_pend  = 1'b0;
            end else begin
                i_read = 1'b0;
                i_pend = 1'b0;
            end
            release_mem();
        end
        repeat (2) tick();
        check("t6 i resp count", line_t'(i_resp_seen - base_i), line_t'(issued_i));
        check("t6 d resp count", line_t'(d_resp_seen - base_d), line_t'(issued_d));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two L1 caches and the cacheline adaptor.
- Arbitrates one full-line transaction at a time and gives the data side priority.
- A starvation guard guarantees forward progress for instruction fetch.

Parameters:
- LINE_W, 256, cache line width in bits
- STARVE_MAX, 4, consecutive D grants allowed while I is pending before I is forced; legal range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_addr  in  32  I-cache line address (rv32i_word)
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, level
- d_write  in  1  D-cache line writeback request, level
- d_addr  in  32  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_addr  out  32  memory line address
- pmem_wdata  out  LINE_W  memory write line
- pmem_rdata  in  LINE_W  memory read line
- pmem_resp  in  1  memory completion pulse

Behaviour:
- States: ARB_IDLE, ARB_IMEM, ARB_DMEM. State is registered; all outputs are decoded from the state and the latched request.
- Reset (async, immediate):
  - state=ARB_IDLE, starve_cnt=0, latched addr/wdata/op=0.
  - All outputs are 0: pmem_read, pmem_write, i_resp, d_resp, pmem_addr, pmem_wdata, i_rdata, d_rdata.
  - Reset mid-transaction drops the strobes the same cycle. No resp is issued for the aborted transaction. pmem_resp arriving while in ARB_IDLE is ignored.
- ARB_IDLE grant, evaluated each cycle:
  - If (d_read|d_write) and !(i_read && starve_cnt==STARVE_MAX): go to ARB_DMEM.
  - Else if i_read: go to ARB_IMEM.
  - Else: stay in ARB_IDLE.
- On grant, latch addr, wdata and op (write if d_write, else read).
  - d_read & d_write together is illegal; write wins and a simulation assertion fires.
- Starvation counter, 4 bits:
  - Increments (saturating at STARVE_MAX) on each DMEM grant while i_read=1.
  - Clears on an IMEM grant and whenever i_read=0 in IDLE.
- ARB_IMEM: pmem_read=1, pmem_addr=latched addr.
  - On pmem_resp: i_resp=1 (same cycle, combinational), i_rdata=pmem_rdata, next state ARB_IDLE.
- ARB_DMEM: pmem_read or pmem_write per the latched op, pmem_addr=latched addr, pmem_wdata=latched wdata.
  - On pmem_resp: d_resp=1, and d_rdata=pmem_rdata for reads; next state ARB_IDLE.
- rdata outputs: pass pmem_rdata only in the resp cycle, 0 otherwise.
- Latency: a request sampled in IDLE at edge t drives the strobe from t+1. Resp is issued in the pmem_resp cycle.
  - There is one mandatory IDLE cycle between transactions, so back-to-back grants are at least 1 bubble apart.
- Requester deasserting mid-transaction: the transaction still completes and resp still pulses. Inputs are ignored outside IDLE because latched values drive pmem.
- pmem_read and pmem_write are never both 1; i_resp and d_resp are never both 1.

Decomposition:
- Package arbiter_types:
  - enum arb_state_t {ARB_IDLE, ARB_IMEM, ARB_DMEM}
  - enum arb_op_t {ARB_OP_READ, ARB_OP_WRITE}
  - localparam STARVE_W=4
- One sub-module, arb_starve_ctr: saturating counter with inc, clr and at_max outputs; parameter MAX; async active-high rst.

Test Plan:
- Lone I read, i_addr=0x0000_1000; pmem_resp after 5 cycles with rdata=0xA5..A5 -> pmem_read=1 from cycle 1 to 5; i_resp=1 in cycle 5 with i_rdata=0xA5..A5; IDLE in cycle 6.
- d_write and i_read asserted together, d_addr=0x2000 -> DMEM granted first with pmem_write=1 and pmem_wdata=d_wdata; after d_resp, the IMEM grant follows after one IDLE cycle.
- D requests kept continuously asserted, i_read held, STARVE_MAX=4 -> exactly 4 DMEM grants, then 1 IMEM grant, then the counter returns to 0.
- D-cache drops d_read the cycle after the grant; memory responds later -> pmem_read held until pmem_resp; d_resp still pulses once.
- rst asserted in the middle of ARB_DMEM -> pmem_write=0 in the same cycle with no clock edge; state ARB_IDLE; a later stray pmem_resp produces no i_resp or d_resp.
- Randomised traffic with a scoreboard -> every request receives exactly one resp with correct data and address; the strobe and resp exclusivity assertions never fire.
